// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: debounces keypad codes, builds two 8-bit
// decimal operands, hands them to an external ALU and displays the result.
module calc_entry_ctrl #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic [1:0] op,
    output logic       start,
    output logic [7:0] disp_value,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam logic [7:0] DebLimit = 8'(DEBOUNCE);

    typedef enum logic [2:0] {
        StEntryA = 3'd0,
        StEntryB = 3'd1,
        StStart  = 3'd2,
        StWait   = 3'd3,
        StShow   = 3'd4
    } state_e;

    // Press detector state
    logic       armed_q, armed_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] last_key_q, last_key_d;
    logic       key_evt;

    // Entry state
    state_e     state_q, state_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [1:0] op_q, op_d;
    logic [7:0] res_q, res_d;
    logic       err_q, err_d;
    logic [1:0] digits_q, digits_d;

    // Decoded event key and accumulator arithmetic
    logic        is_digit, is_oper, is_clear, is_equals, is_bksp;
    logic [7:0]  acc_sel;
    logic [11:0] acc_mul;
    logic [7:0]  acc_new;
    logic        acc_wr;

    assign is_digit  = (last_key_q <= 4'd9);
    assign is_oper   = (last_key_q >= 4'd10) && (last_key_q <= 4'd12);
    assign is_clear  = (last_key_q == 4'd13);
    assign is_equals = (last_key_q == 4'd14);
    assign is_bksp   = (last_key_q == 4'd15);

    assign acc_sel = (state_q == StEntryB) ? opb_q : opa_q;
    assign acc_mul = {4'd0, acc_sel} * 12'd10 + {8'd0, last_key_q};

    // Debounce: count stable key cycles while armed, release cycles while disarmed
    always_comb begin
        armed_d    = armed_q;
        cnt_d      = cnt_q;
        last_key_d = last_key_q;
        key_evt    = armed_q && (cnt_q == DebLimit);
        if (armed_q) begin
            if (key_evt) begin
                armed_d = 1'b0;
                cnt_d   = 8'd0;
            end else if (!key_valid) begin
                cnt_d = 8'd0;
            end else if (cnt_q == 8'd0 || key_value != last_key_q) begin
                cnt_d      = 8'd1;
                last_key_d = key_value;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            if (key_valid) begin
                cnt_d = 8'd0;
            end else if (cnt_q + 8'd1 == DebLimit) begin
                armed_d = 1'b1;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Entry FSM next state and datapath
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        res_d    = res_q;
        err_d    = err_q;
        digits_d = digits_q;
        acc_new  = acc_sel;
        acc_wr   = 1'b0;

        unique case (state_q)
            StEntryA, StEntryB: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (digits_q == 2'd3 || acc_mul > 12'd255) begin
                            err_d = 1'b1;
                        end else begin
                            acc_new  = acc_mul[7:0];
                            acc_wr   = 1'b1;
                            digits_d = digits_q + 2'd1;
                        end
                    end else if (is_bksp) begin
                        if (digits_q != 2'd0) begin
                            acc_new  = acc_sel / 8'd10;
                            acc_wr   = 1'b1;
                            digits_d = digits_q - 2'd1;
                        end
                    end else if (is_oper) begin
                        op_d = 2'(last_key_q - 4'd10);
                        if (state_q == StEntryA) begin
                            if (digits_q == 2'd0) begin
                                opa_d = 8'd0;
                            end
                            opb_d    = 8'd0;
                            digits_d = 2'd0;
                            state_d  = StEntryB;
                        end
                    end else if (is_equals && state_q == StEntryB) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                // alu_done wins over a coincident key; only clear survives below
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (key_evt) begin
                    if (is_digit) begin
                        opa_d    = {4'd0, last_key_q};
                        digits_d = 2'd1;
                        state_d  = StEntryA;
                    end else if (is_oper) begin
                        opa_d    = res_q;
                        opb_d    = 8'd0;
                        op_d     = 2'(last_key_q - 4'd10);
                        digits_d = 2'd0;
                        state_d  = StEntryB;
                    end
                end
            end
            default: begin
                state_d = StEntryA;
            end
        endcase

        if (acc_wr) begin
            if (state_q == StEntryB) begin
                opb_d = acc_new;
            end else begin
                opa_d = acc_new;
            end
        end

        // Clear overrides everything, in any state
        if (key_evt && is_clear) begin
            opa_d    = 8'd0;
            opb_d    = 8'd0;
            op_d     = 2'd0;
            err_d    = 1'b0;
            digits_d = 2'd0;
            state_d  = StEntryA;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            cnt_q      <= 8'd0;
            last_key_q <= 4'd0;
            state_q    <= StEntryA;
            opa_q      <= 8'd0;
            opb_q      <= 8'd0;
            op_q       <= 2'd0;
            res_q      <= 8'd0;
            err_q      <= 1'b0;
            digits_q   <= 2'd0;
        end else begin
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            last_key_q <= last_key_d;
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            res_q      <= res_d;
            err_q      <= err_d;
            digits_q   <= digits_d;
        end
    end

    // Outputs: display follows the operand being edited, else the last result
    always_comb begin
        unique case (state_q)
            StEntryA: disp_value = opa_q;
            StEntryB: disp_value = opb_q;
            default:  disp_value = res_q;
        endcase
    end

    assign operand_a = opa_q;
    assign operand_b = opb_q;
    assign op        = op_q;
    assign err       = err_q;
    assign start     = (state_q == StStart);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with hand-computed expectations.
module tb_calc_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key_value = 4'd0;
    logic       key_valid = 1'b0;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'd0;
    logic [7:0] operand_a, operand_b, disp_value;
    logic [1:0] op;
    logic       start, err;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    calc_entry_ctrl #(.DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op         (op),
        .start      (start),
        .disp_value (disp_value),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Count start pulses away from the active edge
    always @(negedge clk) if (start) start_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        @(negedge clk);
        key_value = k;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic alu_pulse(input logic [7:0] r);
        @(negedge clk);
        alu_result = r;
        alu_done   = 1'b1;
        @(negedge clk);
        alu_done   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", state_dbg, 0);
        check("rst_opa", operand_a, 0);
        check("rst_opb", operand_b, 0);
        check("rst_op", op, 0);
        check("rst_start", start, 0);
        check("rst_disp", disp_value, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 123 + 4 =
        press(4'd1, 6); press(4'd2, 6); press(4'd3, 6);
        check("a_123", operand_a, 123);
        check("disp_a", disp_value, 123);
        press(4'd10, 6);
        check("st_b", state_dbg, 1);
        check("op_add", op, 0);
        press(4'd4, 6);
        check("b_4", operand_b, 4);
        check("disp_b", disp_value, 4);
        start_cnt = 0;
        press(4'd14, 6);
        check("start_once", start_cnt, 1);
        check("st_wait", state_dbg, 3);
        check("a_kept", operand_a, 123);
        alu_pulse(8'd127);
        check("disp_127", disp_value, 127);
        check("st_show", state_dbg, 4);

        // Chain from 127, then get result 9 and chain again
        press(4'd12, 6);
        check("chain_a", operand_a, 127);
        check("chain_st", state_dbg, 1);
        press(4'd3, 6);
        press(4'd14, 6);
        alu_pulse(8'd9);
        check("disp_9", disp_value, 9);
        start_cnt = 0;
        press(4'd12, 6); press(4'd3, 6); press(4'd14, 6);
        check("ch9_a", operand_a, 9);
        check("ch9_b", operand_b, 3);
        check("ch9_op", op, 2);
        check("ch9_start", start_cnt, 1);

        // Keys in WAIT: digit ignored, clear honoured, late alu_done dropped
        press(4'd7, 6);
        check("wait_dig_st", state_dbg, 3);
        check("wait_dig_disp", disp_value, 9);
        press(4'd13, 6);
        check("wait_clr_st", state_dbg, 0);
        check("wait_clr_a", operand_a, 0);
        alu_pulse(8'd55);
        check("late_done_disp", disp_value, 0);
        check("late_done_st", state_dbg, 0);

        // Overflow, backspace, clear
        press(4'd2, 6); press(4'd5, 6); press(4'd6, 6);
        check("ovf_err", err, 1);
        check("ovf_a", operand_a, 25);
        press(4'd15, 6);
        check("bksp_a", operand_a, 2);
        check("bksp_err", err, 1);
        press(4'd13, 6);
        check("clr_err", err, 0);
        check("clr_a", operand_a, 0);
        press(4'd15, 6);
        check("bksp_empty", operand_a, 0);

        // Debounce: short hold, toggling, long hold
        press(4'd5, 3);
        check("short_hold", operand_a, 0);
        @(negedge clk);
        key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            key_value = (i % 2 == 0) ? 4'd5 : 4'd6;
            repeat (2) @(negedge clk);
        end
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("toggle", operand_a, 0);
        press(4'd8, 50);
        check("long_hold", operand_a, 8);

        // 255 boundary and three-digit limit
        press(4'd13, 6);
        press(4'd2, 6); press(4'd5, 6); press(4'd5, 6);
        check("a_255", operand_a, 255);
        check("err_255", err, 0);
        press(4'd1, 6);
        check("limit_a", operand_a, 255);
        check("limit_err", err, 1);

        // Equals in ENTRY_A is ignored
        press(4'd14, 6);
        check("eq_in_a", state_dbg, 0);

        // Async reset mid-press, then release required before the next press
        press(4'd13, 6);
        press(4'd6, 6);
        @(negedge clk);
        key_value = 4'd4;
        key_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_a", operand_a, 0);
        check("async_disp", disp_value, 0);
        check("async_st", state_dbg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_through_rst", operand_a, 0);
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        press(4'd3, 6);
        check("after_rst_press", operand_a, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
